// File: rtl/s_instr.sv
// ----------------------------------------------------------------------------
// s_instr
// Registered decoder for RV32 S-type (store) instructions. It splits the
// instruction word into its S-type fields, rebuilds the sign-extended store
// immediate, and classifies the access size and byte mask. Outputs appear
// one cycle after a valid word is sampled. When in_valid is low, only
// out_valid drops and every other output keeps its last decode.
//
// Parameters
//   XLEN        width of the sign-extended immediate imm_s (>= 13)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; clears every output
//   in_valid    instr_word is valid this cycle
//   instr_word  RV32 instruction word
//   out_valid   outputs hold the decode of a valid input
//   imm_S_MSB   instr_word[31:25]
//   rs2         instr_word[24:20]
//   rs1         instr_word[19:15]
//   imm_S_LSB   instr_word[11:7]
//   funct3      instr_word[14:12]
//   imm_s       {imm_S_MSB, imm_S_LSB} sign-extended to XLEN
//   is_store    opcode is STORE (7'b0100011)
//   store_size  00 byte, 01 half, 10 word, 11 invalid / not a store
//   byte_mask   unaligned base mask: 0001, 0011, 1111, or 0000
//   illegal     store opcode with an unsupported funct3
// ----------------------------------------------------------------------------
module s_instr #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr_word,
  output logic            out_valid,
  output logic [6:0]      imm_S_MSB,
  output logic [4:0]      rs2,
  output logic [4:0]      rs1,
  output logic [4:0]      imm_S_LSB,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm_s,
  output logic            is_store,
  output logic [1:0]      store_size,
  output logic [3:0]      byte_mask,
  output logic            illegal
);

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [11:0]     imm12;
  logic [XLEN-1:0] imm_ext;
  logic            store_d;
  logic [1:0]      size_d;
  logic [3:0]      mask_d;
  logic            illegal_d;

  assign imm12   = {instr_word[31:25], instr_word[11:7]};
  assign imm_ext = {{(XLEN-12){imm12[11]}}, imm12};
  assign store_d = (instr_word[6:0] == OPC_STORE);

  // Non-store opcodes decode as "invalid size, no lanes" but are not flagged
  // illegal; illegal is reserved for malformed stores.
  always_comb begin
    size_d    = 2'b11;
    mask_d    = 4'b0000;
    illegal_d = 1'b0;
    if (store_d) begin
      unique case (instr_word[14:12])
        3'b000: begin
          size_d = 2'b00;
          mask_d = 4'b0001;
        end
        3'b001: begin
          size_d = 2'b01;
          mask_d = 4'b0011;
        end
        3'b010: begin
          size_d = 2'b10;
          mask_d = 4'b1111;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      imm_S_MSB  <= '0;
      rs2        <= '0;
      rs1        <= '0;
      imm_S_LSB  <= '0;
      funct3     <= '0;
      imm_s      <= '0;
      is_store   <= 1'b0;
      store_size <= '0;
      byte_mask  <= '0;
      illegal    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm_S_MSB  <= instr_word[31:25];
        rs2        <= instr_word[24:20];
        rs1        <= instr_word[19:15];
        imm_S_LSB  <= instr_word[11:7];
        funct3     <= instr_word[14:12];
        imm_s      <= imm_ext;
        is_store   <= store_d;
        store_size <= size_d;
        byte_mask  <= mask_d;
        illegal    <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_s_instr.sv
// ----------------------------------------------------------------------------
// tb_s_instr
// Directed and randomized checks of s_instr against a behavioural model that
// derives each expected output arithmetically from the instruction word.
// ----------------------------------------------------------------------------
module tb_s_instr;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [31:0]     instr_word;
  logic            out_valid;
  logic [6:0]      imm_S_MSB;
  logic [4:0]      rs2;
  logic [4:0]      rs1;
  logic [4:0]      imm_S_LSB;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_s;
  logic            is_store;
  logic [1:0]      store_size;
  logic [3:0]      byte_mask;
  logic            illegal;

  s_instr #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .instr_word (instr_word),
    .out_valid  (out_valid),
    .imm_S_MSB  (imm_S_MSB),
    .rs2        (rs2),
    .rs1        (rs1),
    .imm_S_LSB  (imm_S_LSB),
    .funct3     (funct3),
    .imm_s      (imm_s),
    .is_store   (is_store),
    .store_size (store_size),
    .byte_mask  (byte_mask),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the outputs should show right now.
  longint unsigned e_valid, e_msb, e_rs2, e_rs1, e_lsb, e_f3, e_imm;
  longint unsigned e_store, e_size, e_mask, e_ill;

  task automatic check(input string tag, input longint unsigned obs,
                       input longint unsigned exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    e_valid = 0; e_msb = 0; e_rs2 = 0; e_rs1 = 0; e_lsb = 0; e_f3 = 0;
    e_imm = 0; e_store = 0; e_size = 0; e_mask = 0; e_ill = 0;
  endtask

  // Expected decode from the instruction-set rules, using plain arithmetic.
  task automatic model_load(input logic [31:0] w);
    longint signed imm_val;
    longint unsigned u;
    u       = w;
    e_valid = 1;
    e_msb   = (u >> 25) % 128;
    e_rs2   = (u >> 20) % 32;
    e_rs1   = (u >> 15) % 32;
    e_lsb   = (u >> 7) % 32;
    e_f3    = (u >> 12) % 8;
    imm_val = longint'(e_msb * 32 + e_lsb);
    if (imm_val >= 2048) imm_val = imm_val - 4096;
    e_imm   = longint'(imm_val) % (64'd1 << XLEN);
    if (imm_val < 0) e_imm = (64'd1 << XLEN) + imm_val;
    e_store = ((u % 128) == 35) ? 1 : 0;
    if (e_store == 1 && e_f3 < 3) begin
      e_size = e_f3;                          // size in log2(bytes)
      e_mask = (64'd1 << (64'd1 << e_f3)) - 1; // 2^bytes - 1 low lanes
      e_ill  = 0;
    end else begin
      e_size = 3;
      e_mask = 0;
      e_ill  = e_store;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"},  out_valid,  e_valid);
    check({tag, ".imm_S_MSB"},  imm_S_MSB,  e_msb);
    check({tag, ".rs2"},        rs2,        e_rs2);
    check({tag, ".rs1"},        rs1,        e_rs1);
    check({tag, ".imm_S_LSB"},  imm_S_LSB,  e_lsb);
    check({tag, ".funct3"},     funct3,     e_f3);
    check({tag, ".imm_s"},      imm_s,      e_imm);
    check({tag, ".is_store"},   is_store,   e_store);
    check({tag, ".store_size"}, store_size, e_size);
    check({tag, ".byte_mask"},  byte_mask,  e_mask);
    check({tag, ".illegal"},    illegal,    e_ill);
  endtask

  // Drive one cycle of input, let the DUT sample it, then compare.
  task automatic step(input logic v, input logic [31:0] w, input string tag);
    in_valid   = v;
    instr_word = w;
    @(posedge clk);
    #1;
    if (v) model_load(w);
    else   e_valid = 0;
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 3);
    if (sel <= 1)      w[6:0] = 7'b0100011;
    else if (sel == 2) w[6:0] = 7'b0110011;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    instr_word = '0;
    model_reset();
    #3;
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_held");
    rst_n = 1'b1;

    step(1'b0, 32'hFFFF_FFFF, "idle_after_reset");

    // Directed vectors for S-type stores.
    step(1'b1, 32'b0000111_00000_01101_010_11101_0100011, "sw_pos");
    step(1'b1, 32'b0100101_10101_01100_010_01111_0100011, "sw_pos2");
    step(1'b1, 32'b1000100_01011_00111_010_00001_0100011, "sw_neg");
    step(1'b1, 32'b1000100_01011_00111_000_00001_0100011, "sb");
    step(1'b1, 32'b1000100_01011_00111_001_00001_0100011, "sh");
    step(1'b1, 32'b1000100_01011_00111_011_00001_0100011, "illegal_f3");
    step(1'b1, 32'b0000000_00011_00010_000_00001_0110011, "rtype");
    step(1'b1, 32'b1111111_11111_11111_111_11111_0100011, "all_ones_store");

    // Idle cycles hold the last decode while out_valid drops.
    step(1'b0, 32'h0000_0000, "hold1");
    step(1'b0, 32'h1234_5678, "hold2");
    step(1'b1, 32'b0000000_00000_00000_010_00000_0100011, "sw_zero");

    // Randomized stream, mostly valid so back-to-back decodes are exercised.
    for (int i = 0; i < 300; i++) begin
      w = rand_word();
      step(($urandom_range(0, 3) != 0), w, "rand");
    end

    // Reset in the middle of a valid stream discards the pending decode.
    step(1'b1, 32'b1000100_01011_00111_010_00001_0100011, "pre_reset");
    in_valid   = 1'b1;
    instr_word = 32'b0100101_10101_01100_001_01111_0100011;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset_async");
    @(posedge clk); #1;
    check_all("mid_reset_held");
    rst_n    = 1'b1;
    step(1'b0, 32'hDEAD_BEEF, "post_reset_idle");
    step(1'b1, 32'b0100101_10101_01100_001_01111_0100011, "post_reset_sh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s_instr.md
S_INSTR -- requirements
Module: s_instr

Interface
REQ-001 Parameter: XLEN, default 32, width of sign-extended immediate output imm_s.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  instr_word is valid this cycle.
REQ-006 instr_word  input  32  RV32 instruction word to decode.
REQ-007 out_valid  output  1  registered outputs hold a decode of a valid input.
REQ-008 imm_S_MSB  output  7  instr_word[31:25].
REQ-009 rs2  output  5  instr_word[24:20].
REQ-010 rs1  output  5  instr_word[19:15].
REQ-011 imm_S_LSB  output  5  instr_word[11:7].
REQ-012 funct3  output  3  instr_word[14:12].
REQ-013 imm_s  output  XLEN  {imm_S_MSB, imm_S_LSB} sign-extended from bit 11.
REQ-014 is_store  output  1  opcode instr_word[6:0] == 7'b0100011.
REQ-015 store_size  output  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 invalid.
REQ-016 byte_mask  output  4  unaligned base mask: SB 0001, SH 0011, SW 1111, else 0000.
REQ-017 illegal  output  1  is_store high and funct3 not in {000,001,010}.

Function
REQ-018 All outputs SHALL be registered; latency exactly 1 cycle from in_valid/instr_word sampled at a rising edge to outputs.
REQ-019 On a rising edge with in_valid=1, all field, decode and immediate registers SHALL load from instr_word and out_valid SHALL become 1.
REQ-020 On a rising edge with in_valid=0, out_valid SHALL become 0 and all other outputs SHALL hold their previous values.
REQ-021 Field extraction (imm_S_MSB, rs2, rs1, imm_S_LSB, funct3) SHALL be performed regardless of opcode.
REQ-022 imm_s SHALL equal the 12-bit value {instr_word[31:25], instr_word[11:7]} with bit 11 replicated into bits XLEN-1..12.
REQ-023 When is_store=0, store_size SHALL be 11, byte_mask 0000 and illegal 0.
REQ-024 When is_store=1, store_size and byte_mask SHALL follow funct3: 000 -> 00/0001, 001 -> 01/0011, 010 -> 10/1111, other -> 11/0000 with illegal=1.
REQ-025 Back-to-back valid inputs SHALL produce back-to-back decodes with no bubbles; no backpressure exists.
REQ-026 Outputs SHALL never contain X after reset, for any instr_word value, including X-free inputs with in_valid=0.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0 immediately (asynchronous), including out_valid, imm_s, store_size and byte_mask.
REQ-028 Reset asserted mid-stream SHALL discard the pending decode; the first rising edge after rst_n deasserts SHALL behave per REQ-019/REQ-020.

Verification
REQ-029 instr_word=0000111_00000_01101_010_11101_0100011, in_valid=1 -> next cycle imm_S_MSB=7, rs2=0, rs1=13, imm_S_LSB=29, funct3=2, imm_s=0x000000FD, is_store=1, store_size=10, byte_mask=1111, illegal=0.
REQ-030 instr_word=0100101_10101_01100_010_01111_0100011 -> imm_S_MSB=37, rs2=21, rs1=12, imm_S_LSB=15, imm_s=0x000004AF, store_size=10.
REQ-031 instr_word=1000100_01011_00111_010_00001_0100011 -> imm_S_MSB=68, rs2=11, rs1=7, imm_S_LSB=1, imm_s=0xFFFFF881 (negative immediate sign-extends).
REQ-032 Same fields with funct3=000, then 001, then 011 -> store_size 00/01/11, byte_mask 0001/0011/0000, illegal 0/0/1.
REQ-033 Opcode 0110011 (R-type) with valid=1 -> fields extracted, is_store=0, store_size=11, byte_mask=0000, illegal=0.
REQ-034 Reset pulse during a valid stream, then in_valid=0 -> all outputs 0 during reset, out_valid=0 after.
